acc_sram_arb: RTL and testbench
===============================

# acc_sram_arb

Two-requester arbiter that shares one single-port accelerator SRAM (IFM, weight or result buffer) between the ICB host path and the conv core. It picks at most one command per cycle and registers it onto the SRAM port. It tracks each in-flight read and returns the read data to the requester that issued it. One instance sits in front of each `sirv_sim_ram` in the accelerator top.

## Interface
- `AW`, default 13: SRAM word-address width (8192 words).
- `DW`, default 32: data width.
- `MW`, default DW/8: write byte-mask width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `h_req` in 1: host command request.
- `h_gnt` out 1: host command accepted this cycle.
- `h_we`, `h_addr`, `h_wdata`, `h_wmask` in 1/AW/DW/MW: host command fields.
- `h_rsp_valid` out 1: host read data valid.
- `h_rsp_rdata` out DW: host read data.
- `c_req`, `c_gnt`, `c_we`, `c_addr`, `c_wdata`, `c_wmask`, `c_rsp_valid`, `c_rsp_rdata`: the same set for the conv core.
- `core_lock` in 1: conv layer running. The host is blocked while this is high.
- `ram_cs`, `ram_we` out 1: SRAM chip select and write enable (registered).
- `ram_addr` out AW: SRAM address (registered).
- `ram_din` out DW: SRAM write data (registered).
- `ram_wem` out MW: SRAM byte write mask (registered).
- `ram_dout` in DW: SRAM read data, valid one cycle after a read cs.
- `h_wait` out 1: high while `h_req` is pending and not granted.

## Operation
- Grant logic is combinational. At most one of `h_gnt`/`c_gnt` is high in any cycle. A requester's grant is never high unless its `req` is high.
- A command is accepted when `req & gnt` are both high. Command fields must be stable while `req` is high and not yet granted.
- `core_lock`=1 forces `h_gnt`=0. `c_gnt` follows `c_req` directly in that case.
- With `core_lock`=0 and only one request pending, that request is granted.
- With `core_lock`=0 and both requests pending, the winner is chosen by the arbitration policy (see Configuration).
- Accepted command is copied to the `ram_*` registers. Cycles with no grant drive `ram_cs`=0 and `ram_we`=0. `ram_addr`, `ram_din` and `ram_wem` hold their last value.
- A two-stage tag pipeline carries a read flag and an owner bit (0 = host, 1 = core) alongside each accepted command. Writes produce no response.
- `h_rsp_rdata` and `c_rsp_rdata` are both driven from `ram_dout` combinationally. They are meaningful only while the matching `rsp_valid` is high.
- There is no response backpressure. Requesters must consume the data in the cycle it is valid.
- `h_wait` = `h_req & ~h_gnt`. It exists for the host bridge to hold its ICB `cmd_ready` low.

## Timing
- Cycle T: accept.
- Cycle T+1: `ram_cs`/`ram_we`/`ram_addr`/`ram_din`/`ram_wem` present the command.
- Cycle T+2: `ram_dout` is valid. The owner's `rsp_valid`=1 for exactly one cycle.
- Read latency: 2 cycles from accept to data.
- Throughput: one accept per cycle, back-to-back, with mixed owners allowed. Responses return in accept order.
- A write at T followed by a read of the same address at T+1 returns the new data, because the SRAM sees the write first.
- Reset values:
  - `ram_cs`, `ram_we`, both `rsp_valid` and all tag stages: 0.
  - `ram_addr`, `ram_din`, `ram_wem`: 0.
  - Round-robin pointer: "host last", so the core wins the first conflict.
- Reset asserted mid-operation: in-flight reads are dropped and no `rsp_valid` pulse follows the release of reset.
- `core_lock` rising while a host read is in flight does not cancel it. The read completes normally.

## Configuration
- `ACC_ARB_RR_EN` defined:
  - Round-robin between host and core on conflict. The winner is the requester not granted at the most recent conflicted accept.
  - The pointer updates only on cycles where both requested and one was granted.
- `ACC_ARB_RR_EN` undefined:
  - Fixed priority, core over host.
  - No pointer register.
  - `h_wait` may stay high indefinitely while `c_req` is continuously high.

## Structure
- Shared package `acc_pkg` holds:
  - `ACC_RAM_AW`=13 and `ACC_RAM_DW`=32.
  - The owner encoding `OWN_HOST`=0 and `OWN_CORE`=1.
  - A typedef for the command bundle {we, addr, wdata, wmask}.
- No sub-module. The arbiter is flat; the tag pipeline is two flops of {rd, owner}.

## Test plan
- Host-only write to 0x0010 with data 0xA5A5_5A5A and mask 0xF, then host read of 0x0010 → `ram_cs` pulses at T+1 for each command; `h_rsp_valid` at T+2 of the read with `h_rsp_rdata`=0xA5A5_5A5A; `c_rsp_valid` stays 0.
- `h_req` and `c_req` both held high for 4 cycles with `core_lock`=0:
  - with `ACC_ARB_RR_EN` defined → grants go C,H,C,H;
  - without it → grants go C,C,C,C and `h_wait`=1 throughout.
- Back-to-back core reads of 0x0000, 0x0001 and 0x0002 (preloaded 1, 2, 3) → `c_rsp_valid` high for 3 consecutive cycles with data 1, 2, 3 in order.
- `core_lock`=1 with `h_req`=1 and `c_req`=0 for 5 cycles → `h_gnt`=0, `ram_cs`=0 and `h_wait`=1. Dropping the lock → `h_gnt`=1 in that same cycle.
- Host read accepted, then `rst_n` pulsed low at T+1 → no `h_rsp_valid` pulse after reset release; all `ram_*` outputs read 0 during reset.
- Interleaved accepts H-read of 0x0005, C-write to 0x0005 with 0x1234, C-read of 0x0005 → `h_rsp` returns the old value, `c_rsp` returns 0x1234, and each pulse goes only to its owner.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator SRAM arbiters: default SRAM geometry,
// requester owner encoding, command bundle and the read-tag carried alongside it.
package acc_pkg;

  localparam int ACC_RAM_AW = 13;
  localparam int ACC_RAM_DW = 32;
  localparam int ACC_RAM_MW = ACC_RAM_DW / 8;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CORE = 1'b1
  } acc_own_t;

  // One SRAM command as presented by either requester.
  typedef struct packed {
    logic                  we;
    logic [ACC_RAM_AW-1:0] addr;
    logic [ACC_RAM_DW-1:0] wdata;
    logic [ACC_RAM_MW-1:0] wmask;
  } acc_cmd_t;

  // Travels with each accepted command so read data finds its way home.
  typedef struct packed {
    logic     rd;
    acc_own_t owner;
  } acc_tag_t;

endpackage

// File: rtl/acc_sram_arb.sv
// Host / conv-core arbiter in front of one single-port accelerator SRAM.
// Define ACC_ARB_RR_EN for round-robin on conflict; default is core-over-host priority.
module acc_sram_arb
  import acc_pkg::*;
#(
  parameter int AW = ACC_RAM_AW,
  parameter int DW = ACC_RAM_DW,
  parameter int MW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          h_req,
  output logic          h_gnt,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic [MW-1:0] h_wmask,
  output logic          h_rsp_valid,
  output logic [DW-1:0] h_rsp_rdata,
  output logic          h_wait,

  input  logic          c_req,
  output logic          c_gnt,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [MW-1:0] c_wmask,
  output logic          c_rsp_valid,
  output logic [DW-1:0] c_rsp_rdata,

  input  logic          core_lock,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } cmd_t;

  logic     h_win;
  logic     accept;
  cmd_t     sel_cmd;
  acc_tag_t tag_s1;
  acc_tag_t tag_s2;

`ifdef ACC_ARB_RR_EN
  // Records who won the most recent conflict; reset to host so the core wins the first one.
  logic last_core;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_core <= 1'b0;
    end else if (h_req && c_req && (h_gnt || c_gnt)) begin
      last_core <= c_gnt;
    end
  end

  assign h_win = last_core;
`else
  assign h_win = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    h_gnt = 1'b0;
    c_gnt = 1'b0;
    if (core_lock) begin
      c_gnt = c_req;
    end else if (h_req && c_req) begin
      h_gnt = h_win;
      c_gnt = ~h_win;
    end else begin
      h_gnt = h_req;
      c_gnt = c_req;
    end
  end

  assign accept = h_gnt | c_gnt;
  assign h_wait = h_req & ~h_gnt;

  always_comb begin
    if (c_gnt) begin
      sel_cmd = '{we: c_we, addr: c_addr, wdata: c_wdata, wmask: c_wmask};
    end else begin
      sel_cmd = '{we: h_we, addr: h_addr, wdata: h_wdata, wmask: h_wmask};
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_wem  <= '0;
    end else if (accept) begin
      ram_cs   <= 1'b1;
      ram_we   <= sel_cmd.we;
      ram_addr <= sel_cmd.addr;
      ram_din  <= sel_cmd.wdata;
      ram_wem  <= sel_cmd.wmask;
    end else begin
      // Address and data hold so the SRAM pins do not toggle on idle cycles.
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
    end
  end

  // Stage 1 lines up with the SRAM command, stage 2 with ram_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1.rd    <= accept & ~sel_cmd.we;
      tag_s1.owner <= c_gnt ? OWN_CORE : OWN_HOST;
      tag_s2       <= tag_s1;
    end
  end

  assign h_rsp_valid = tag_s2.rd && (tag_s2.owner == OWN_HOST);
  assign c_rsp_valid = tag_s2.rd && (tag_s2.owner == OWN_CORE);
  assign h_rsp_rdata = ram_dout;
  assign c_rsp_rdata = ram_dout;

endmodule

// File: tb/tb_acc_sram_arb.sv
// Directed bench for acc_sram_arb with a behavioural single-port SRAM behind it.
// Expected arbitration order follows ACC_ARB_RR_EN when the bench is built with it.
module tb_acc_sram_arb;
  import acc_pkg::*;

  localparam int AW = ACC_RAM_AW;
  localparam int DW = ACC_RAM_DW;
  localparam int MW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          h_req, h_gnt, h_we, h_rsp_valid, h_wait;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata, h_rsp_rdata;
  logic [MW-1:0] h_wmask;
  logic          c_req, c_gnt, c_we, c_rsp_valid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rsp_rdata;
  logic [MW-1:0] c_wmask;
  logic          core_lock;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [MW-1:0] ram_wem;

  int n_checks = 0;
  int n_fail   = 0;

  acc_sram_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_req      (h_req),
    .h_gnt      (h_gnt),
    .h_we       (h_we),
    .h_addr     (h_addr),
    .h_wdata    (h_wdata),
    .h_wmask    (h_wmask),
    .h_rsp_valid(h_rsp_valid),
    .h_rsp_rdata(h_rsp_rdata),
    .h_wait     (h_wait),
    .c_req      (c_req),
    .c_gnt      (c_gnt),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_wmask    (c_wmask),
    .c_rsp_valid(c_rsp_valid),
    .c_rsp_rdata(c_rsp_rdata),
    .core_lock  (core_lock),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_wem    (ram_wem),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with byte mask and one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_h(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
    h_req = req; h_we = we; h_addr = addr; h_wdata = wdata; h_wmask = wmask;
  endtask

  task automatic set_c(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wdata; c_wmask = wmask;
  endtask

  task automatic idle(input int n);
    set_h(1'b0, 1'b0, '0, '0, '0);
    set_c(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic exp_c_gnt [4];

  initial begin
    rst_n = 1'b0;
    core_lock = 1'b0;
    ram_dout = '0;
    set_h(1'b0, 1'b0, '0, '0, '0);
    set_c(1'b0, 1'b0, '0, '0, '0);
    #2;
    check("rst_ram_cs",   ram_cs, 0);
    check("rst_ram_we",   ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din",  ram_din, 0);
    check("rst_ram_wem",  ram_wem, 0);
    check("rst_h_rsp",    h_rsp_valid, 0);
    check("rst_c_rsp",    c_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Host write then host read of 0x0010.
    tick();
    set_h(1'b1, 1'b1, 13'h0010, 32'hA5A5_5A5A, 4'hF);
    #1;
    check("hw_gnt",  h_gnt, 1);
    check("hw_cgnt", c_gnt, 0);
    check("hw_wait", h_wait, 0);
    tick();
    set_h(1'b1, 1'b0, 13'h0010, 32'h0, 4'h0);
    #1;
    check("hw_ram_cs",   ram_cs, 1);
    check("hw_ram_we",   ram_we, 1);
    check("hw_ram_addr", ram_addr, 13'h0010);
    check("hw_ram_din",  ram_din, 32'hA5A5_5A5A);
    check("hw_ram_wem",  ram_wem, 4'hF);
    check("hr_gnt",      h_gnt, 1);
    tick();
    set_h(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("hr_ram_cs",  ram_cs, 1);
    check("hr_ram_we",  ram_we, 0);
    check("hw_no_rsp",  h_rsp_valid, 0);
    tick();
    check("hr_rsp_v",    h_rsp_valid, 1);
    check("hr_rsp_data", h_rsp_rdata, 32'hA5A5_5A5A);
    check("hr_c_rsp",    c_rsp_valid, 0);
    check("idle_cs",     ram_cs, 0);
    check("idle_addr_hold", ram_addr, 13'h0010);
    tick();
    check("hr_rsp_once", h_rsp_valid, 0);

    // Conflict: both request writes for 4 cycles.
`ifdef ACC_ARB_RR_EN
    exp_c_gnt = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_c_gnt = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      set_h(1'b1, 1'b1, 13'h0200, 32'h2222_2222, 4'hF);
      set_c(1'b1, 1'b1, 13'h0300, 32'h3333_3333, 4'hF);
      #1;
      check($sformatf("cf_c_gnt%0d", i), c_gnt, exp_c_gnt[i]);
      check($sformatf("cf_h_gnt%0d", i), h_gnt, !exp_c_gnt[i]);
      check($sformatf("cf_h_wait%0d", i), h_wait, exp_c_gnt[i]);
      tick();
      check($sformatf("cf_ram_addr%0d", i), ram_addr, exp_c_gnt[i] ? 13'h0300 : 13'h0200);
    end
    idle(3);

    // Core writes 1,2,3 to 0..2, reads them back-to-back, plus masked write.
    for (int i = 0; i < 9; i++) begin
      if (i < 3)      set_c(1'b1, 1'b1, AW'(i), DW'(i + 1), 4'hF);
      else if (i < 6) set_c(1'b1, 1'b0, AW'(i - 3), '0, '0);
      else            set_c(1'b0, 1'b0, '0, '0, '0);
      #1;
      if (i >= 2) begin
        check($sformatf("bb_c_rsp%0d", i), c_rsp_valid, (i >= 5 && i <= 7));
        check($sformatf("bb_h_rsp%0d", i), h_rsp_valid, 0);
        if (i >= 5 && i <= 7) check($sformatf("bb_data%0d", i), c_rsp_rdata, DW'(i - 4));
      end
      tick();
    end
    set_c(1'b1, 1'b1, 13'h0006, 32'h1234_5678, 4'hF);
    tick();
    set_c(1'b1, 1'b1, 13'h0006, 32'hFFFF_FFFF, 4'h3);
    tick();
    set_c(1'b1, 1'b0, 13'h0006, '0, '0);
    tick();
    set_c(1'b0, 1'b0, '0, '0, '0);
    tick();
    check("mask_rsp_v",    c_rsp_valid, 1);
    check("mask_rsp_data", c_rsp_rdata, 32'h1234_FFFF);
    idle(2);

    // core_lock blocks the host; dropping it grants in the same cycle.
    core_lock = 1'b1;
    set_h(1'b1, 1'b1, 13'h0040, 32'h0000_0040, 4'hF);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("lk_h_gnt%0d", i), h_gnt, 0);
      check($sformatf("lk_h_wait%0d", i), h_wait, 1);
      check($sformatf("lk_ram_cs%0d", i), ram_cs, 0);
      tick();
    end
    core_lock = 1'b0;
    #1;
    check("unlk_h_gnt",  h_gnt, 1);
    check("unlk_h_wait", h_wait, 0);
    tick();
    set_h(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("unlk_ram_cs", ram_cs, 1);
    idle(3);

    // Reset while a host read is in flight.
    set_h(1'b1, 1'b0, 13'h0010, 32'h5555_AAAA, 4'hF);
    tick();
    check("rf_ram_cs", ram_cs, 1);
    set_h(1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("rf_ram_cs0",   ram_cs, 0);
    check("rf_ram_we0",   ram_we, 0);
    check("rf_ram_addr0", ram_addr, 0);
    check("rf_ram_din0",  ram_din, 0);
    check("rf_ram_wem0",  ram_wem, 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rf_no_rsp%0d", i), h_rsp_valid, 0);
    end

    // Interleaved H-read / C-write / C-read of 0x0005.
    set_h(1'b1, 1'b1, 13'h0005, 32'h0BAD_F00D, 4'hF);
    tick();
    set_h(1'b1, 1'b0, 13'h0005, '0, '0);
    tick();
    set_h(1'b0, 1'b0, '0, '0, '0);
    set_c(1'b1, 1'b1, 13'h0005, 32'h0000_1234, 4'hF);
    tick();
    set_c(1'b1, 1'b0, 13'h0005, '0, '0);
    #1;
    check("il_h_rsp_v",    h_rsp_valid, 1);
    check("il_h_rsp_data", h_rsp_rdata, 32'h0BAD_F00D);
    check("il_c_rsp_v0",   c_rsp_valid, 0);
    tick();
    set_c(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("il_h_rsp_v1", h_rsp_valid, 0);
    check("il_c_rsp_v1", c_rsp_valid, 0);
    tick();
    check("il_c_rsp_v",    c_rsp_valid, 1);
    check("il_c_rsp_data", c_rsp_rdata, 32'h0000_1234);
    check("il_h_rsp_v2",   h_rsp_valid, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
